// File: rtl/ow_temp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ow_temp_sequencer
// Brief    : Drives a 1-Wire byte engine through a DS18B20-style temperature
//            measurement: reset, Skip ROM, Convert T, conversion wait, reset,
//            Skip ROM, Read Scratchpad, read LSB/MSB, then publishes 9 bits.
// Revision : 1.0 - initial release
// ============================================================================
module ow_temp_sequencer #(
  parameter int PERIOD      = 100_000_000,
  parameter int CONV_WAIT   = 75_000_000,
  parameter int ENG_TIMEOUT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       trig,
  output logic [1:0] eng_cmd,
  output logic [7:0] eng_wdata,
  output logic       eng_start,
  input  logic       eng_done,
  input  logic       eng_presence,
  input  logic [7:0] eng_rdata,
  output logic [8:0] temp,
  output logic       temp_valid,
  output logic       no_dev,
  output logic       busy
);

  localparam logic [1:0] C_OP_RESET = 2'b00;
  localparam logic [1:0] C_OP_WRITE = 2'b01;
  localparam logic [1:0] C_OP_READ  = 2'b10;

  localparam logic [7:0] C_SKIP_ROM      = 8'hCC;
  localparam logic [7:0] C_CONVERT_T     = 8'h44;
  localparam logic [7:0] C_READ_SCRATCH  = 8'hBE;

  localparam logic [31:0] C_PERIOD_LAST = 32'(PERIOD - 1);
  localparam logic [31:0] C_CONV_LAST   = 32'(CONV_WAIT - 1);
  // The timeout counter is cleared on the eng_start edge, so it lags the
  // elapsed cycle count by one; this value makes the abort edge the
  // ENG_TIMEOUT-th edge after the eng_start cycle.
  localparam logic [31:0] C_TMO_LAST    = 32'(ENG_TIMEOUT - 2);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_RST1  = 4'd1,
    S_SKIP1 = 4'd2,
    S_CONVT = 4'd3,
    S_WAITC = 4'd4,
    S_RST2  = 4'd5,
    S_SKIP2 = 4'd6,
    S_RDCMD = 4'd7,
    S_RDLSB = 4'd8,
    S_RDMSB = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_first;        // first cycle of a state: launch cycle for engine ops
  logic [31:0] r_period_cnt;
  logic [31:0] r_conv_cnt;
  logic [31:0] r_tmo_cnt;
  logic [7:0]  r_lsb;

  logic        w_eng_state;
  logic        w_wait;
  logic        w_done;
  logic        w_timeout;
  logic        w_no_presence;
  logic        w_abort;
  logic        w_seq_ok;
  logic        w_is_rst;

  // Next-state selection and engine command decode
  always_comb begin
    w_next        = r_state;
    eng_cmd       = C_OP_RESET;
    eng_wdata     = 8'h00;
    w_eng_state   = 1'b1;
    w_is_rst      = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_eng_state = 1'b0;
      end
      S_WAITC: begin
        w_eng_state = 1'b0;
      end
      S_RST1, S_RST2: begin
        eng_cmd  = C_OP_RESET;
        w_is_rst = 1'b1;
      end
      S_SKIP1, S_SKIP2: begin
        eng_cmd   = C_OP_WRITE;
        eng_wdata = C_SKIP_ROM;
      end
      S_CONVT: begin
        eng_cmd   = C_OP_WRITE;
        eng_wdata = C_CONVERT_T;
      end
      S_RDCMD: begin
        eng_cmd   = C_OP_WRITE;
        eng_wdata = C_READ_SCRATCH;
      end
      S_RDLSB, S_RDMSB: begin
        eng_cmd = C_OP_READ;
      end
      default: begin
        w_eng_state = 1'b0;
      end
    endcase

    // eng_done only counts once the launch cycle is over
    w_wait        = w_eng_state && !r_first;
    w_done        = w_wait && eng_done;
    w_timeout     = w_wait && !eng_done && (r_tmo_cnt == C_TMO_LAST);
    w_no_presence = w_done && w_is_rst && !eng_presence;
    w_abort       = w_timeout || w_no_presence;
    w_seq_ok      = w_done && (r_state == S_RDMSB);

    eng_start = w_eng_state && r_first;
    busy      = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (trig || (en && (r_period_cnt == C_PERIOD_LAST))) begin
          w_next = S_RST1;
        end
      end
      S_WAITC: begin
        if (r_conv_cnt == C_CONV_LAST) begin
          w_next = S_RST2;
        end
      end
      default: begin
        if (w_abort) begin
          w_next = S_IDLE;
        end else if (w_done) begin
          case (r_state)
            S_RST1:  w_next = S_SKIP1;
            S_SKIP1: w_next = S_CONVT;
            S_CONVT: w_next = S_WAITC;
            S_RST2:  w_next = S_SKIP2;
            S_SKIP2: w_next = S_RDCMD;
            S_RDCMD: w_next = S_RDLSB;
            S_RDLSB: w_next = S_RDMSB;
            default: w_next = S_IDLE;
          endcase
        end
      end
    endcase
  end

  // State register; r_first marks the cycle after every state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_next;
      r_first <= (w_next != r_state);
    end
  end

  // Period counter: runs only while idling with en high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period_cnt <= 32'd0;
    end else if ((r_state != S_IDLE) || !en || (w_next != S_IDLE)) begin
      r_period_cnt <= 32'd0;
    end else begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end

  // Conversion wait counter: counts WAITC cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conv_cnt <= 32'd0;
    end else if ((r_state == S_WAITC) && (w_next == S_WAITC)) begin
      r_conv_cnt <= r_conv_cnt + 32'd1;
    end else begin
      r_conv_cnt <= 32'd0;
    end
  end

  // Engine timeout counter: restarts on every launch, counts while waiting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= 32'd0;
    end else if (eng_start) begin
      r_tmo_cnt <= 32'd0;
    end else if (w_wait) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end else begin
      r_tmo_cnt <= 32'd0;
    end
  end

  // Result capture and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lsb      <= 8'h00;
      temp       <= 9'h000;
      temp_valid <= 1'b0;
      no_dev     <= 1'b0;
    end else begin
      temp_valid <= w_seq_ok;
      if (w_done && (r_state == S_RDLSB)) begin
        r_lsb <= eng_rdata;
      end
      // Only bit 0 of the MSB byte carries the sign/high bit we publish
      if (w_seq_ok) begin
        temp <= {eng_rdata[0], r_lsb};
      end
      if (w_abort) begin
        no_dev <= 1'b1;
      end else if (w_seq_ok) begin
        no_dev <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ow_temp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ow_temp_sequencer
// Brief    : Scoreboard bench for ow_temp_sequencer with a 10-cycle engine
//            model; expected engine ops and temperatures are queued by the
//            stimulus thread and consumed by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ow_temp_sequencer;

  logic       clk;
  logic       reset;
  logic       en;
  logic       trig;
  logic [1:0] eng_cmd;
  logic [7:0] eng_wdata;
  logic       eng_start;
  logic       eng_done;
  logic       eng_presence;
  logic [7:0] eng_rdata;
  logic [8:0] temp;
  logic       temp_valid;
  logic       no_dev;
  logic       busy;

  ow_temp_sequencer #(
    .PERIOD      (100),
    .CONV_WAIT   (50),
    .ENG_TIMEOUT (200)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .trig         (trig),
    .eng_cmd      (eng_cmd),
    .eng_wdata    (eng_wdata),
    .eng_start    (eng_start),
    .eng_done     (eng_done),
    .eng_presence (eng_presence),
    .eng_rdata    (eng_rdata),
    .temp         (temp),
    .temp_valid   (temp_valid),
    .no_dev       (no_dev),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0] cmd;
    logic [7:0] wdata;
    int         gap;   // expected cycles since previous eng_start, 0 = not checked
  } op_t;

  op_t        exp_ops[$];
  logic [8:0] exp_temp[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_start_cyc = 0;

  // engine model controls
  logic [7:0] rd_lsb = 8'h00;
  logic [7:0] rd_msb = 8'h00;
  bit         fail_rst2 = 0;
  bit         withhold_skip = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_op(input logic [1:0] c, input logic [7:0] d, input int g);
    op_t o;
    o.cmd = c;
    o.wdata = d;
    o.gap = g;
    exp_ops.push_back(o);
  endtask

  // Full measurement: each op's done arrives 10 cycles after launch and the
  // next launch follows one edge later (11); CONVT to RST2 adds 50 wait cycles.
  task automatic push_seq();
    push_op(2'b00, 8'h00, 0);
    push_op(2'b01, 8'hCC, 11);
    push_op(2'b01, 8'h44, 11);
    push_op(2'b00, 8'h00, 61);
    push_op(2'b01, 8'hCC, 11);
    push_op(2'b01, 8'hBE, 11);
    push_op(2'b10, 8'h00, 11);
    push_op(2'b10, 8'h00, 11);
  endtask

  task automatic pulse_trig();
    @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    chk("busy after trig", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(input int limit, output int at_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    if (busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, required 0", limit);
    end
  endtask

  task automatic wait_start(input int limit, output int at_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (!eng_start && n < limit) begin
      @(negedge clk);
      n++;
    end
    at_cyc = cyc;
    if (!eng_start) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_start: no eng_start within %0d cycles, required 1", limit);
    end
  endtask

  // Engine model: answers each launch with done 10 cycles later
  initial begin
    int         pending;
    bit         after_conv;
    bit         rd_second;
    logic       pend_pres;
    logic [7:0] pend_data;
    pending = 0;
    after_conv = 0;
    rd_second = 0;
    pend_pres = 1'b1;
    pend_data = 8'h00;
    eng_done = 1'b0;
    eng_presence = 1'b0;
    eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (reset) begin
        pending = 0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            eng_done = 1'b1;
            eng_presence = pend_pres;
            eng_rdata = pend_data;
          end
        end
        if (eng_start && !(withhold_skip && eng_cmd == 2'b01 && eng_wdata == 8'hCC)) begin
          pending = 10;
          pend_pres = 1'b1;
          pend_data = 8'h00;
          if (eng_cmd == 2'b00) begin
            pend_pres = !(fail_rst2 && after_conv);
            after_conv = 0;
            rd_second = 0;
          end else if (eng_cmd == 2'b01) begin
            if (eng_wdata == 8'h44) after_conv = 1;
          end else begin
            pend_data = rd_second ? rd_msb : rd_lsb;
            rd_second = 1;
          end
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT launches an op or publishes a temperature
  initial begin
    op_t        o;
    logic [8:0] et;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (eng_start) begin
          if (exp_ops.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected eng_start: cmd=%0h wdata=0x%0h, required no launch", eng_cmd, eng_wdata);
          end else begin
            o = exp_ops.pop_front();
            chk("op cmd", {30'd0, eng_cmd}, {30'd0, o.cmd});
            if (o.cmd == 2'b01) chk("op wdata", {24'd0, eng_wdata}, {24'd0, o.wdata});
            if (o.gap != 0) chk("op spacing", cyc - last_start_cyc, o.gap);
          end
          last_start_cyc = cyc;
        end
        if (temp_valid) begin
          if (exp_temp.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected temp_valid: temp=0x%0h, required no pulse", temp);
          end else begin
            et = exp_temp.pop_front();
            chk("temp value", {23'd0, temp}, {23'd0, et});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int t0;
    int t1;
    int n;
    reset = 1'b1;
    en = 1'b0;
    trig = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset eng_start", {31'd0, eng_start}, 32'd0);
    chk("reset eng_cmd", {30'd0, eng_cmd}, 32'd0);
    chk("reset eng_wdata", {24'd0, eng_wdata}, 32'd0);
    chk("reset temp", {23'd0, temp}, 32'd0);
    chk("reset no_dev", {31'd0, no_dev}, 32'd0);
    reset = 1'b0;

    // no autonomous start with en low
    repeat (150) @(negedge clk);
    chk("idle without request", {31'd0, busy}, 32'd0);

    // trig, 0x32/0x00 -> 0x032
    rd_lsb = 8'h32; rd_msb = 8'h00;
    push_seq(); exp_temp.push_back(9'h032);
    pulse_trig();
    wait_idle(600, t0);
    chk("A no_dev", {31'd0, no_dev}, 32'd0);
    chk("A temp", {23'd0, temp}, 32'h032);

    // trig, 0xCE/0xFF -> 0x1CE
    rd_lsb = 8'hCE; rd_msb = 8'hFF;
    push_seq(); exp_temp.push_back(9'h1CE);
    pulse_trig();
    wait_idle(600, t0);
    chk("B no_dev", {31'd0, no_dev}, 32'd0);
    chk("B temp", {23'd0, temp}, 32'h1CE);

    // no presence on the second reset -> abort one edge after done
    fail_rst2 = 1;
    push_op(2'b00, 8'h00, 0);
    push_op(2'b01, 8'hCC, 11);
    push_op(2'b01, 8'h44, 11);
    push_op(2'b00, 8'h00, 61);
    pulse_trig();
    wait_idle(600, t0);
    chk("C abort latency", t0 - last_start_cyc, 32'd11);
    chk("C no_dev", {31'd0, no_dev}, 32'd1);
    chk("C temp held", {23'd0, temp}, 32'h1CE);
    fail_rst2 = 0;

    // periodic measurement; trig while busy must add nothing
    rd_lsb = 8'h50; rd_msb = 8'h01;
    push_seq(); exp_temp.push_back(9'h150);
    @(negedge clk);
    en = 1'b1;
    t0 = cyc;
    wait_start(300, t1);
    chk("D first period", t1 - t0, 32'd100);
    repeat (30) @(negedge clk);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    wait_idle(600, t0);
    chk("D no_dev cleared", {31'd0, no_dev}, 32'd0);
    chk("D temp", {23'd0, temp}, 32'h150);
    push_seq(); exp_temp.push_back(9'h150);
    wait_start(300, t1);
    chk("D period after idle", t1 - t0, 32'd100);
    en = 1'b0;
    wait_idle(600, t0);
    repeat (250) @(negedge clk);
    chk("D no queued trig", {31'd0, busy}, 32'd0);

    // engine never answers Skip ROM -> timeout abort
    withhold_skip = 1;
    push_op(2'b00, 8'h00, 0);
    push_op(2'b01, 8'hCC, 11);
    pulse_trig();
    wait_idle(600, t0);
    chk("E timeout latency", t0 - last_start_cyc, 32'd200);
    chk("E no_dev", {31'd0, no_dev}, 32'd1);
    chk("E temp held", {23'd0, temp}, 32'h150);
    withhold_skip = 0;

    // asynchronous reset in the middle of the conversion wait
    push_op(2'b00, 8'h00, 0);
    push_op(2'b01, 8'hCC, 11);
    push_op(2'b01, 8'h44, 11);
    pulse_trig();
    n = 0;
    while (exp_ops.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    chk("F busy in WAITC", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("F reset busy", {31'd0, busy}, 32'd0);
    chk("F reset eng_start", {31'd0, eng_start}, 32'd0);
    chk("F reset eng_cmd", {30'd0, eng_cmd}, 32'd0);
    chk("F reset eng_wdata", {24'd0, eng_wdata}, 32'd0);
    chk("F reset temp", {23'd0, temp}, 32'd0);
    chk("F reset temp_valid", {31'd0, temp_valid}, 32'd0);
    chk("F reset no_dev", {31'd0, no_dev}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (250) @(negedge clk);
    chk("F stays idle", {31'd0, busy}, 32'd0);

    // a fresh trig works after reset
    rd_lsb = 8'h7D; rd_msb = 8'h00;
    push_seq(); exp_temp.push_back(9'h07D);
    pulse_trig();
    wait_idle(600, t0);
    chk("G temp", {23'd0, temp}, 32'h07D);
    chk("G no_dev", {31'd0, no_dev}, 32'd0);

    repeat (5) @(negedge clk);
    chk("ops drained", exp_ops.size(), 32'd0);
    chk("temps drained", exp_temp.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
